// File: rtl/uart_rx_deser_if.sv
// Bus between RX bit-timing logic and the receive deserialiser.
// The upstream side drives strobes; the deserialiser returns words and status.
interface uart_rx_deser_if #(
   parameter int DATA_WIDTH = 8
);
   localparam int CNT_W = $clog2(DATA_WIDTH + 2);

   logic                  shift;
   logic                  serial_in;
   logic                  clear;
   logic [DATA_WIDTH-1:0] parallel_out;
   logic                  data_valid;
   logic                  parity_err;
   logic                  busy;
   logic [CNT_W-1:0]      bit_cnt;

   modport master (
      output shift,
      output serial_in,
      output clear,
      input  parallel_out,
      input  data_valid,
      input  parity_err,
      input  busy,
      input  bit_cnt
   );

   modport slave (
      input  shift,
      input  serial_in,
      input  clear,
      output parallel_out,
      output data_valid,
      output parity_err,
      output busy,
      output bit_cnt
   );
endinterface

// File: rtl/uart_rx_deser.sv
// UART receive deserialiser: configurable bit order, optional parity check,
// one-cycle word-valid pulse, frame abort and wrap-around bit counter.
module uart_rx_deser #(
   parameter int DATA_WIDTH = 8,
   parameter int MSB_FIRST  = 0,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                  rx_clk,
   input  logic                  rst,
   uart_rx_deser_if.slave        bus
);
   localparam int CNT_W      = $clog2(DATA_WIDTH + 2);
   localparam int FRAME_BITS = DATA_WIDTH + ((PARITY_EN != 0) ? 1 : 0);

   localparam logic [CNT_W-1:0] DW_C   = CNT_W'(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(FRAME_BITS - 1);
   localparam logic             ODD_C  = (PARITY_ODD != 0);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
   logic [DATA_WIDTH-1:0] pout_q, pout_d;
   logic                  dv_q, dv_d;
   logic                  perr_q, perr_d;

   always_ff @(posedge rx_clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sreg_q  <= '0;
         pout_q  <= '0;
         dv_q    <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sreg_q  <= sreg_d;
         pout_q  <= pout_d;
         dv_q    <= dv_d;
         perr_q  <= perr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sreg_d  = sreg_q;
      pout_d  = pout_q;
      dv_d    = 1'b0;
      perr_d  = perr_q;

      if (bus.clear) begin
         cnt_d   = '0;
         state_d = IDLE;
      end else if (bus.shift) begin
         if (cnt_q < DW_C) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
               if (cnt_q == CNT_W'((MSB_FIRST != 0) ? (DATA_WIDTH - 1 - i) : i))
                  sreg_d[i] = bus.serial_in;
            end
         end
         // The final strobe publishes the word including any bit taken this edge.
         if (cnt_q == LAST_C) begin
            pout_d  = sreg_d;
            dv_d    = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
            if (PARITY_EN != 0)
               perr_d = ((^sreg_q) ^ bus.serial_in) != ODD_C;
            else
               perr_d = 1'b0;
         end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = SHIFT;
         end
      end
   end

   assign bus.parallel_out = pout_q;
   assign bus.data_valid   = dv_q;
   assign bus.parity_err   = perr_q;
   assign bus.busy         = (state_q == SHIFT);
   assign bus.bit_cnt      = cnt_q;
endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: LSB-first, MSB-first and even-parity
// instances driven independently from one clock.
module tb_uart_rx_deser;
   logic       rx_clk = 1'b0;
   logic       rst    = 1'b0;
   logic [2:0] sh     = '0;
   logic [2:0] si     = '0;
   logic [2:0] cl     = '0;
   int         tests  = 0;
   int         fails  = 0;
   int         cyc    = 0;

   always #5 rx_clk = ~rx_clk;

   uart_rx_deser_if #(.DATA_WIDTH(8)) ifa ();
   uart_rx_deser_if #(.DATA_WIDTH(8)) ifb ();
   uart_rx_deser_if #(.DATA_WIDTH(8)) ifc ();

   assign ifa.shift = sh[0];
   assign ifa.serial_in = si[0];
   assign ifa.clear = cl[0];
   assign ifb.shift = sh[1];
   assign ifb.serial_in = si[1];
   assign ifb.clear = cl[1];
   assign ifc.shift = sh[2];
   assign ifc.serial_in = si[2];
   assign ifc.clear = cl[2];

   uart_rx_deser #(.DATA_WIDTH(8), .MSB_FIRST(0), .PARITY_EN(0), .PARITY_ODD(0))
      u_a (.rx_clk(rx_clk), .rst(rst), .bus(ifa));
   uart_rx_deser #(.DATA_WIDTH(8), .MSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0))
      u_b (.rx_clk(rx_clk), .rst(rst), .bus(ifb));
   uart_rx_deser #(.DATA_WIDTH(8), .MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(0))
      u_c (.rx_clk(rx_clk), .rst(rst), .bus(ifc));

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge rx_clk);
      #1;
      cyc++;
   endtask

   task automatic bit_in(input int d, input logic b);
      si[d] = b;
      sh[d] = 1'b1;
      step();
      sh[d] = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Sends bits lo..hi of w, lowest first, back to back.
   task automatic send(input int d, input logic [7:0] w, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) bit_in(d, w[i]);
   endtask

   int p1, p2;

   initial begin
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_pout", 32'(ifa.parallel_out), 32'h0);
      chk("rst_dv", 32'(ifa.data_valid), 32'h0);
      chk("rst_perr", 32'(ifc.parity_err), 32'h0);
      chk("rst_cnt", 32'(ifa.bit_cnt), 32'h0);
      chk("rst_busy", 32'(ifa.busy), 32'h0);

      // 1,0,1,1,0,0,1,0 == 0x4D taken LSB first
      send(0, 8'h4D, 0, 6);
      chk("a_cnt7", 32'(ifa.bit_cnt), 32'd7);
      chk("a_busy7", 32'(ifa.busy), 32'h1);
      chk("a_dv7", 32'(ifa.data_valid), 32'h0);
      send(0, 8'h4D, 7, 7);
      chk("a_dv8", 32'(ifa.data_valid), 32'h1);
      chk("a_pout", 32'(ifa.parallel_out), 32'h4D);
      chk("a_cnt_wrap", 32'(ifa.bit_cnt), 32'h0);
      chk("a_busy_end", 32'(ifa.busy), 32'h0);
      idle(1);
      chk("a_dv_drop", 32'(ifa.data_valid), 32'h0);
      chk("a_pout_hold", 32'(ifa.parallel_out), 32'h4D);

      send(1, 8'h4D, 0, 7);
      chk("b_dv", 32'(ifb.data_valid), 32'h1);
      chk("b_pout", 32'(ifb.parallel_out), 32'hB2);

      send(2, 8'h4D, 0, 7);
      chk("c_dv8", 32'(ifc.data_valid), 32'h0);
      chk("c_cnt8", 32'(ifc.bit_cnt), 32'd8);
      bit_in(2, 1'b0);
      chk("c_dv9", 32'(ifc.data_valid), 32'h1);
      chk("c_pout", 32'(ifc.parallel_out), 32'h4D);
      chk("c_perr0", 32'(ifc.parity_err), 32'h0);
      send(2, 8'h4D, 0, 7);
      bit_in(2, 1'b1);
      chk("c_perr1", 32'(ifc.parity_err), 32'h1);
      chk("c_pout2", 32'(ifc.parallel_out), 32'h4D);
      idle(1);
      chk("c_perr_hold", 32'(ifc.parity_err), 32'h1);

      // Abort after 4 bits; the simultaneous strobe must be ignored
      send(0, 8'hFF, 0, 3);
      cl[0] = 1'b1;
      bit_in(0, 1'b1);
      cl[0] = 1'b0;
      chk("clr_cnt", 32'(ifa.bit_cnt), 32'h0);
      chk("clr_busy", 32'(ifa.busy), 32'h0);
      chk("clr_dv", 32'(ifa.data_valid), 32'h0);
      chk("clr_pout", 32'(ifa.parallel_out), 32'h4D);
      send(0, 8'hFF, 0, 7);
      chk("ff_dv", 32'(ifa.data_valid), 32'h1);
      chk("ff_pout", 32'(ifa.parallel_out), 32'hFF);

      send(0, 8'h4D, 0, 2);
      idle(5);
      chk("gap_cnt", 32'(ifa.bit_cnt), 32'd3);
      chk("gap_dv", 32'(ifa.data_valid), 32'h0);
      chk("gap_pout", 32'(ifa.parallel_out), 32'hFF);
      send(0, 8'h4D, 3, 7);
      chk("gap_dv_end", 32'(ifa.data_valid), 32'h1);
      chk("gap_word", 32'(ifa.parallel_out), 32'h4D);

      // Two frames with no idle cycle between them
      send(0, 8'hA5, 0, 7);
      p1 = cyc;
      chk("b2b_dv1", 32'(ifa.data_valid), 32'h1);
      chk("b2b_w1", 32'(ifa.parallel_out), 32'hA5);
      bit_in(0, 1'b0);
      chk("b2b_dv_gap", 32'(ifa.data_valid), 32'h0);
      chk("b2b_cnt1", 32'(ifa.bit_cnt), 32'd1);
      send(0, 8'h3C, 1, 7);
      p2 = cyc;
      chk("b2b_dv2", 32'(ifa.data_valid), 32'h1);
      chk("b2b_w2", 32'(ifa.parallel_out), 32'h3C);
      chk("b2b_spacing", 32'(p2 - p1), 32'd8);

      // Abort coinciding with what would be the completing strobe
      send(0, 8'h0F, 0, 6);
      cl[0] = 1'b1;
      bit_in(0, 1'b0);
      cl[0] = 1'b0;
      chk("clr_last_dv", 32'(ifa.data_valid), 32'h0);
      chk("clr_last_pout", 32'(ifa.parallel_out), 32'h3C);
      chk("clr_last_cnt", 32'(ifa.bit_cnt), 32'h0);

      send(0, 8'hFF, 0, 2);
      rst = 1'b1;
      bit_in(0, 1'b1);
      rst = 1'b0;
      chk("mrst_pout", 32'(ifa.parallel_out), 32'h0);
      chk("mrst_cnt", 32'(ifa.bit_cnt), 32'h0);
      chk("mrst_busy", 32'(ifa.busy), 32'h0);
      chk("mrst_dv", 32'(ifa.data_valid), 32'h0);
      chk("mrst_perr", 32'(ifc.parity_err), 32'h0);
      // The shift register must come back empty: 7 zero bits plus a 1 give 0x80
      send(0, 8'h80, 0, 7);
      chk("mrst_sreg", 32'(ifa.parallel_out), 32'h80);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
Parametrised serial-to-parallel deserialiser for the UART receive path, successor to the fixed-width SIPO. It sits between the RX bit-timing logic, which issues one shift strobe per mid-bit sample, and the RX data/status interface. It adds configurable bit order, an optional parity bit with checking, a one-cycle word-valid pulse, frame abort, and a bit counter that wraps cleanly across back-to-back frames.

Parameters:
DATA_WIDTH, 8, data bits per frame (1..16)
MSB_FIRST, 0, 0 = first received bit lands in bit 0; 1 = first received bit lands in bit DATA_WIDTH-1
PARITY_EN, 0, 1 = one parity bit follows the data bits and is checked
PARITY_ODD, 0, 0 = even parity expected; 1 = odd parity expected (ignored when PARITY_EN=0)

Ports:
rx_clk  input  1  receive clock; all logic on posedge
rst  input  1  synchronous, active-high reset
shift  input  1  sample strobe; capture serial_in this edge
serial_in  input  1  received serial bit
clear  input  1  synchronous frame abort (framing error / break from upstream)
parallel_out  output  DATA_WIDTH  last completed data word
data_valid  output  1  one-cycle pulse: parallel_out updated this cycle
parity_err  output  1  parity result of last completed frame; 0 when PARITY_EN=0
busy  output  1  partial frame in progress (bit_cnt != 0)
bit_cnt  output  $clog2(DATA_WIDTH+2)  bits captured in current frame

Behaviour:
- FRAME_BITS = DATA_WIDTH + PARITY_EN. Internal shift register is DATA_WIDTH bits; the parity bit is captured separately.
- Reset (rst=1 at posedge): parallel_out=0, data_valid=0, parity_err=0, bit_cnt=0, busy=0, and the internal shift register is cleared. Reset overrides clear and shift.
- Priority per edge: rst > clear > shift.
- Two states, derived from bit_cnt:
  - IDLE (bit_cnt=0, busy=0).
  - SHIFT (0<bit_cnt<FRAME_BITS, busy=1).
- shift=1, bit_cnt<DATA_WIDTH: serial_in is stored at index bit_cnt (MSB_FIRST=0) or DATA_WIDTH-1-bit_cnt (MSB_FIRST=1); bit_cnt increments.
- shift=1, bit_cnt=DATA_WIDTH, PARITY_EN=1: serial_in is captured as the parity bit.
- Frame completion is the edge where shift=1 and bit_cnt=FRAME_BITS-1. At that edge:
  - parallel_out is loaded with the full word, including a data bit captured on that same edge.
  - data_valid=1 for exactly the following cycle; otherwise data_valid=0.
  - parity_err = (XOR of data ^ parity bit) != PARITY_ODD when PARITY_EN=1; 0 when PARITY_EN=0.
  - bit_cnt wraps to 0.
- Latency: data_valid and the new parallel_out are visible one cycle after the final shift edge. No dead cycle is required: a shift on the very next edge is bit 0 of the next frame.
- parallel_out and parity_err hold between frames. They change only at frame completion or reset.
- shift=0: no state changes; data_valid returns to 0.
- clear=1 (rst=0): bit_cnt=0 and the partial frame is discarded. A simultaneous shift is ignored. parallel_out and parity_err are unchanged. data_valid=0 that cycle, even if this edge would have completed a frame.
- Reset mid-frame: the partial frame is lost and no data_valid is produced.
- Consecutive shift strobes on every edge are legal. Throughput is one word per FRAME_BITS strobes.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, DATA_WIDTH=8, MSB_FIRST=0, PARITY_EN=0; shift bits 1,0,1,1,0,0,1,0 on consecutive edges -> parallel_out=0x4D, data_valid high exactly 1 cycle after the 8th shift, bit_cnt=0, busy=0.
- Same bit sequence with MSB_FIRST=1 -> parallel_out=0xB2.
- PARITY_EN=1, PARITY_ODD=0:
  - data 0x4D LSB-first then parity 0 -> parity_err=0, data_valid after the 9th shift.
  - parity bit 1 -> parity_err=1, parallel_out=0x4D.
- Strobe gaps: 3 bits, shift low for 5 cycles, 5 more bits -> same word as without gaps, bit_cnt holds 3 during the gap.
- Clear after 4 bits -> bit_cnt=0, busy=0, parallel_out keeps previous 0x4D, no data_valid; next full frame 0xFF -> 0xFF.
- Two frames 0xA5 then 0x3C back-to-back with no idle cycle -> two data_valid pulses 8 cycles apart with correct words; clear asserted with the final shift -> no pulse, parallel_out unchanged; rst mid-frame -> all outputs 0.
